// File: rtl/tpm_pkg.sv
// tpm_pkg: shared ctrl phase codes, state encoding and LFSR constants for the TPM round controller
package tpm_pkg;
  localparam int K_DEF = 2;
  localparam int N_DEF = 3;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [2:0] CTRL_IDLE    = 3'b000;
  localparam logic [2:0] CTRL_INIT    = 3'b001;
  localparam logic [2:0] CTRL_COMPUTE = 3'b010;
  localparam logic [2:0] CTRL_LEARN   = 3'b100;
  localparam logic [2:0] CTRL_SYNC    = 3'b111;
  typedef enum logic [2:0] {IDLE, INIT, COMPUTE, LEARN, SYNCED, FAIL} state_t;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/tpm_sync_master_if.sv
// tpm_sync_master_if: ctrl/feed/out_other bus between the round controller and its two partners
interface tpm_sync_master_if #(parameter int W = 6);
  logic [2:0]   ctrl;
  logic [W-1:0] feed;
  logic         out_a;
  logic         out_b;
  logic         out_to_a;
  logic         out_to_b;
  modport master(output ctrl, feed, out_to_a, out_to_b, input out_a, out_b);
  modport slave(input ctrl, feed, out_to_a, out_to_b, output out_a, out_b);
endinterface

// File: rtl/tpm_sync_master_feed_lfsr.sv
// feed_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11, shifting left); feed is its low W bits
module feed_lfsr
  import tpm_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv_i,
  output logic [W-1:0] feed_o
);
  logic [15:0] lfsr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr_q <= SEED;
    else if (adv_i) lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  assign feed_o = lfsr_q[W-1:0];
endmodule

// File: rtl/tpm_sync_master.sv
// tpm_sync_master: drives partner phases, exchanges partner outputs and tracks agreement until sync or timeout
module tpm_sync_master
  import tpm_pkg::*;
#(
  parameter int K = K_DEF,
  parameter int N = N_DEF,
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int SYNC_ROUNDS = 20,
  parameter int MAX_ROUNDS = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  tpm_sync_master_if.master bus,
  output logic        busy,
  output logic        synced,
  output logic        timeout,
  output logic [15:0] round_count,
  output logic [15:0] agree_streak
);
  localparam int W = K * N;
  localparam logic [15:0] PH_LAST = 16'(W);
  state_t state_q, state_d;
  logic [15:0] tmr_q, tmr_d, rc_q, rc_d, st_q, st_d;
  logic restart_q, restart_d, oa_q, oa_d, ob_q, ob_d, last, adv;
  assign last = tmr_q == PH_LAST;
  assign adv = state_d == COMPUTE && state_q != COMPUTE;
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q + 16'd1;
    rc_d      = rc_q;
    st_d      = st_q;
    restart_d = 1'b0;
    oa_d      = oa_q;
    ob_d      = ob_q;
    case (state_q)
      IDLE:    if (start || restart_q) state_d = INIT;
      INIT:    if (last) state_d = COMPUTE;
      COMPUTE: if (last) begin
        state_d = LEARN;
        oa_d    = bus.out_b;
        ob_d    = bus.out_a;
      end
      LEARN: begin
        rc_d    = sat_inc(rc_q);
        st_d    = (oa_q == ob_q) ? sat_inc(st_q) : 16'd0;
        state_d = (st_d == 16'(SYNC_ROUNDS)) ? SYNCED : (rc_d == 16'(MAX_ROUNDS)) ? FAIL : COMPUTE;
      end
      SYNCED:  if (start) begin
        state_d   = IDLE;
        restart_d = 1'b1;
      end
      FAIL:    if (start) state_d = INIT;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) tmr_d = 16'd0;
    // a new session starts whenever INIT is entered, whichever state it came from
    if (state_d == INIT && state_q != INIT) begin
      rc_d = 16'd0;
      st_d = 16'd0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      tmr_q     <= 16'd0;
      rc_q      <= 16'd0;
      st_q      <= 16'd0;
      restart_q <= 1'b0;
      oa_q      <= 1'b0;
      ob_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      rc_q      <= rc_d;
      st_q      <= st_d;
      restart_q <= restart_d;
      oa_q      <= oa_d;
      ob_q      <= ob_d;
    end
  feed_lfsr #(.SEED(SEED), .W(W)) u_lfsr (.clk(clk), .rst(rst), .adv_i(adv), .feed_o(bus.feed));
  assign bus.ctrl = state_q == INIT ? CTRL_INIT : state_q == COMPUTE ? CTRL_COMPUTE :
                    state_q == LEARN ? CTRL_LEARN : state_q == SYNCED ? CTRL_SYNC : CTRL_IDLE;
  assign bus.out_to_a = oa_q;
  assign bus.out_to_b = ob_q;
  assign busy         = state_q == INIT || state_q == COMPUTE || state_q == LEARN;
  assign synced       = state_q == SYNCED;
  assign timeout      = state_q == FAIL;
  assign round_count  = rc_q;
  assign agree_streak = st_q;
endmodule

// File: doc/tpm_sync_master.md
Name: tpm_sync_master

Overview:
- Round controller for a pair of tree parity machine partners: it drives the shared ctrl phase code and the random feed vector, and exchanges the two partner outputs.
- It counts consecutive agreeing rounds, declares synchronisation by driving ctrl=111, and declares timeout after a round limit.
- It is the initiator side of the partner ctrl/feed/out_other protocol and sits one level above two partner instances.

Parameters:
- K, 2, hidden units per partner
- N, 3, inputs per hidden unit; feed width is K*N
- SEED, 16'hACE1, nonzero initial value of the feed LFSR
- SYNC_ROUNDS, 20, consecutive agreeing rounds required to declare sync (>=1)
- MAX_ROUNDS, 1000, learn rounds before timeout (>=SYNC_ROUNDS)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset; the same rst feeds both partners
- start  in  1  one-cycle pulse; begins a session from IDLE, SYNCED or FAIL
- ctrl  out  3  phase code to both partners: 000 idle, 001 init, 010 compute, 100 learn, 111 synced
- feed  out  K*N  input vector to both partners
- out_a  in  1  partner A out
- out_b  in  1  partner B out
- out_to_a  out  1  partner A out_other; registered copy of out_b
- out_to_b  out  1  partner B out_other; registered copy of out_a
- busy  out  1  high in INIT, COMPUTE and LEARN
- synced  out  1  high in SYNCED
- timeout  out  1  high in FAIL
- round_count  out  16  learn rounds completed this session
- agree_streak  out  16  current run of consecutive agreeing rounds

Behaviour:
- Reset: state IDLE, ctrl=000, LFSR=SEED, feed=SEED[K*N-1:0], out_to_a=out_to_b=0, all counters 0, busy=synced=timeout=0.
- Partners act on rising edges of individual ctrl bits. Every phase entry must therefore raise the bit of the new phase. Legal transitions: 000->001, 001->010, 010->100, 100->010, 100->111, any->000.
- IDLE: ctrl=000. On start, go to INIT. Clear round_count and agree_streak.
- INIT: ctrl=001 for exactly K*N+1 cycles, then go to COMPUTE. Partners need K*N edges to load weights; the extra cycle is margin.
- COMPUTE entry: advance the LFSR once. The LFSR is 16-bit Fibonacci, taps 16,14,13,11, shifting left. feed takes lfsr[K*N-1:0] in the same cycle ctrl becomes 010. feed stays stable through the following LEARN.
- COMPUTE: ctrl=010 for K*N+1 cycles. On the last cycle, register out_to_a<=out_b and out_to_b<=out_a. Go to LEARN.
- LEARN: ctrl=100 for 1 cycle.
  - round_count+1.
  - If the registered outputs are equal, agree_streak+1; otherwise agree_streak=0.
  - Next state, in priority order:
    - updated agree_streak==SYNC_ROUNDS: go to SYNCED (sync wins over timeout on the same round).
    - else updated round_count==MAX_ROUNDS: go to FAIL.
    - else go to COMPUTE.
- SYNCED: ctrl=111 and synced=1, held until start or rst. On start, go to IDLE for one cycle (ctrl=000), then INIT.
- FAIL: ctrl=000 and timeout=1, held. On start, go directly to INIT.
- start while busy is ignored.
- Counters saturate at 16'hFFFF.
- The LFSR is not reseeded on start; each session continues the sequence. Only rst reloads SEED.
- Reset mid-phase: immediate return to reset values. Because partners share rst, no partial-phase recovery is needed.
- out_a/out_b are sampled only on the last COMPUTE cycle. Changes at other times have no effect.

Decomposition:
- Shared package tpm_pkg holds:
  - ctrl encodings CTRL_IDLE/INIT/COMPUTE/LEARN/SYNC
  - default K, N and the LFSR tap mask
  - the state enum IDLE/INIT/COMPUTE/LEARN/SYNCED/FAIL
- One sub-module, feed_lfsr: 16-bit Fibonacci LFSR with SEED parameter and an advance enable; feed is its low K*N bits.
- Phase timer and FSM stay in the top.

Test Plan:
- Tie out_a=out_b=1, SYNC_ROUNDS=4. Pulse start ->
  - ctrl shows 001 for 7 cycles, then 4x(010 for 7 cycles, 100 for 1 cycle), then 111 held.
  - synced=1 immediately after the 4th LEARN; round_count=4.
- Tie out_a=1, out_b=0, MAX_ROUNDS=5 -> agree_streak stays 0; after the 5th LEARN, timeout=1, ctrl=000, synced=0.
- Alternate agreement pattern agree,agree,disagree,agree with SYNC_ROUNDS=3 -> agree_streak sequence 1,2,0,1; no sync.
- Feed check: SEED=16'hACE1 -> feed values in rounds 1..3 match a bench LFSR model. feed is constant across each COMPUTE+LEARN pair and changes only on COMPUTE entry.
- Assert rst mid-COMPUTE (cycle 3) -> ctrl=000, feed=6'h21, counters 0 in the same cycle. Next start restarts with INIT of 7 cycles.
- In SYNCED, pulse start -> one cycle ctrl=000, then 001. start pulsed during COMPUTE -> no effect on ctrl sequence.
- Integration: two partner instances (partner_no 0 and 1) on the bench -> every ctrl transition raises the new phase bit; assertion checker reports no illegal transitions.
